// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared memory-side constants and the block-transfer FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Memory word width and byte-address width
    localparam int WORD_WIDTH      = 32;

    // Size of the attached memory in bytes
    localparam int MEM_DEPTH_BYTES = 4096;

    // Byte stride between consecutive words
    localparam int WORD_BYTES      = WORD_WIDTH / 8;

    // Block-transfer FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_SRC = 3'd1,
        ST_WR_DST = 3'd2,
        ST_RD_DST = 3'd3,
        ST_FIN    = 3'd4
    } xfer_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/blk_xfer_addr.sv
`default_nettype none
// ============================================================================
// Module      : blk_xfer_addr
// Description : Word index counter and the source/destination address sums
//               derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module blk_xfer_addr
    import mem_pkg::*;
#(
    parameter int WORD_WIDTH = mem_pkg::WORD_WIDTH,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_clr,
    input  logic                  i_inc,
    input  logic [WORD_WIDTH-1:0] i_src_base,
    input  logic [WORD_WIDTH-1:0] i_dst_base,
    output logic [LEN_WIDTH-1:0]  o_idx,
    output logic [WORD_WIDTH-1:0] o_src_cur,
    output logic [WORD_WIDTH-1:0] o_dst_cur,
    output logic [WORD_WIDTH-1:0] o_src_nxt
);

    logic [LEN_WIDTH-1:0]  r_idx;
    logic [WORD_WIDTH-1:0] w_off_cur;

    // Word index: cleared on an accepted start, advanced after each word
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + LEN_WIDTH'(1);
        end
    end

    // Byte offset of the current word; all sums wrap modulo 2^WORD_WIDTH
    assign w_off_cur = WORD_WIDTH'({r_idx, 2'b00});
    assign o_idx     = r_idx;
    assign o_src_cur = i_src_base + w_off_cur;
    assign o_dst_cur = i_dst_base + w_off_cur;
    // Source address of the following word, used to pre-load the address
    // register when moving on to the next RD_SRC
    assign o_src_nxt = o_src_cur + WORD_WIDTH'(WORD_BYTES);

endmodule : blk_xfer_addr
`default_nettype wire

// File: rtl/blk_xfer.sv
`default_nettype none
// ============================================================================
// Module      : blk_xfer
// Description : Memory block copy / compare engine. Two cycles per word
//               (read source, then write or read destination), one FIN
//               cycle with a done pulse. All memory-side outputs are
//               registered and pre-loaded for the state being entered.
// Revision    : 1.0 - initial release
// ============================================================================
module blk_xfer
    import mem_pkg::*;
#(
    parameter int WORD_WIDTH = mem_pkg::WORD_WIDTH,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [WORD_WIDTH-1:0] src_addr,
    input  logic [WORD_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len_words,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  mismatch_cnt,
    output logic [WORD_WIDTH-1:0] first_mis_addr,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    xfer_state_t           r_state;
    logic                  r_mode;
    logic [WORD_WIDTH-1:0] r_src;
    logic [WORD_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [WORD_WIDTH-1:0] r_buf;
    logic                  r_busy;
    logic                  r_done;
    logic [LEN_WIDTH-1:0]  r_mis_cnt;
    logic [WORD_WIDTH-1:0] r_first_mis;
    logic [WORD_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_wr;
    logic [WORD_WIDTH-1:0] r_mem_wdata;

    logic                  w_accept;
    logic                  w_word_end;
    logic                  w_last;
    logic                  w_unequal;
    logic [LEN_WIDTH-1:0]  w_idx;
    logic [WORD_WIDTH-1:0] w_src_cur;
    logic [WORD_WIDTH-1:0] w_dst_cur;
    logic [WORD_WIDTH-1:0] w_src_nxt;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_word_end = (r_state == ST_WR_DST) || (r_state == ST_RD_DST);
    assign w_last     = ((w_idx + LEN_WIDTH'(1)) == r_len);
    assign w_unequal  = (mem_rdata != r_buf);

    blk_xfer_addr #(
        .WORD_WIDTH (WORD_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr (
        .clk        (clk),
        .nrst       (nrst),
        .i_clr      (w_accept),
        .i_inc      (w_word_end),
        .i_src_base (r_src),
        .i_dst_base (r_dst),
        .o_idx      (w_idx),
        .o_src_cur  (w_src_cur),
        .o_dst_cur  (w_dst_cur),
        .o_src_nxt  (w_src_nxt)
    );

    // Transfer FSM; memory outputs are set up for the state being entered
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_mode      <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_buf       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mis_cnt   <= '0;
            r_first_mis <= '0;
            r_mem_addr  <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_done      <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_mem_addr <= '0;
                    if (start) begin
                        r_mode      <= mode;
                        r_src       <= src_addr;
                        r_dst       <= dst_addr;
                        r_len       <= len_words;
                        r_mis_cnt   <= '0;
                        r_first_mis <= '0;
                        r_busy      <= 1'b1;
                        if (len_words == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_RD_SRC;
                            r_mem_addr <= src_addr;
                        end
                    end
                end
                ST_RD_SRC: begin
                    r_buf      <= mem_rdata;
                    r_mem_addr <= w_dst_cur;
                    if (!r_mode) begin
                        r_state     <= ST_WR_DST;
                        r_mem_wr    <= 1'b1;
                        r_mem_wdata <= mem_rdata;
                    end else begin
                        r_state <= ST_RD_DST;
                    end
                end
                ST_WR_DST, ST_RD_DST: begin
                    if ((r_state == ST_RD_DST) && w_unequal) begin
                        if (r_mis_cnt == '0) begin
                            r_first_mis <= w_src_cur;
                        end
                        if (r_mis_cnt != '1) begin
                            r_mis_cnt <= r_mis_cnt + LEN_WIDTH'(1);
                        end
                    end
                    if (w_last) begin
                        r_state    <= ST_FIN;
                        r_mem_addr <= '0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= ST_RD_SRC;
                        r_mem_addr <= w_src_nxt;
                    end
                end
                ST_FIN: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_mem_addr <= '0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_mem_addr <= '0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign mismatch_cnt   = r_mis_cnt;
    assign first_mis_addr = r_first_mis;
    assign mem_addr       = r_mem_addr;
    assign mem_wr         = r_mem_wr;
    assign mem_wdata      = r_mem_wdata;

endmodule : blk_xfer
`default_nettype wire

// File: tb/tb_blk_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_blk_xfer
// Description : Directed self-checking bench for blk_xfer with a 4 KiB
//               big-endian byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blk_xfer;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic [15:0] mismatch_cnt;
    logic [31:0] first_mis_addr;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mem [0:4095];
    logic [11:0] a0;

    logic [31:0] tr_addr  [0:31];
    logic        tr_wr    [0:31];
    logic [31:0] tr_wdata [0:31];

    blk_xfer #(
        .WORD_WIDTH (32),
        .LEN_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start          (start),
        .mode           (mode),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len_words      (len_words),
        .busy           (busy),
        .done           (done),
        .mismatch_cnt   (mismatch_cnt),
        .first_mis_addr (first_mis_addr),
        .mem_addr       (mem_addr),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian memory: combinational read, write committed at rising edge
    assign a0        = mem_addr[11:0];
    assign mem_rdata = {mem[a0], mem[a0 + 12'd1], mem[a0 + 12'd2], mem[a0 + 12'd3]};

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[a0]         = mem_wdata[31:24];
            mem[a0 + 12'd1] = mem_wdata[23:16];
            mem[a0 + 12'd2] = mem_wdata[15:8];
            mem[a0 + 12'd3] = mem_wdata[7:0];
        end
    end

    task automatic mem_clear();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    endtask

    task automatic put_word(input logic [11:0] a, input logic [31:0] d);
        mem[a]         = d[31:24];
        mem[a + 12'd1] = d[23:16];
        mem[a + 12'd2] = d[15:8];
        mem[a + 12'd3] = d[7:0];
    endtask

    function automatic logic [31:0] get_word(input logic [11:0] a);
        return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
    endfunction

    task automatic load_source();
        put_word(12'h000, 32'h11223344);
        put_word(12'h004, 32'h55667788);
        put_word(12'h008, 32'h99AABBCC);
        put_word(12'h00C, 32'hDDEEFF00);
    endtask

    // Launch one transfer and observe a fixed 30-cycle window; optionally
    // pulse a second start (different source) at cycle inj_cyc
    task automatic run_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input int inj_cyc,
                            output int done_cyc, output int busy_cyc,
                            output int done_cnt, output int wr_cnt);
        done_cyc = 0; busy_cyc = 0; done_cnt = 0; wr_cnt = 0;
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len_words = n;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tr_addr[cyc]  = mem_addr;
            tr_wr[cyc]    = mem_wr;
            tr_wdata[cyc] = mem_wdata;
            if (busy) busy_cyc++;
            if (mem_wr) wr_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == inj_cyc) begin
                start = 1'b1; src_addr = 32'h200; len_words = 16'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %h want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %h want 0", done); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr got %h want 0", mem_wr); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (mismatch_cnt !== 16'h0) $display("FAIL reset_mis_cnt got %h want 0", mismatch_cnt); else n_pass++;
        n_checks++; if (first_mis_addr !== 32'h0) $display("FAIL reset_first_mis got %h want 0", first_mis_addr); else n_pass++;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_copy();
        int dc, bc, dn, wc;
        mem_clear(); load_source();
        run_xfer(1'b0, 32'h000, 32'h100, 16'd4, 0, dc, bc, dn, wc);
        n_checks++; if (dc != 9) $display("FAIL copy_done_cycle got %0d want 9", dc); else n_pass++;
        n_checks++; if (bc != 9) $display("FAIL copy_busy_cycles got %0d want 9", bc); else n_pass++;
        n_checks++; if (dn != 1) $display("FAIL copy_done_pulses got %0d want 1", dn); else n_pass++;
        n_checks++; if (wc != 4) $display("FAIL copy_writes got %0d want 4", wc); else n_pass++;
        n_checks++; if (tr_addr[1] !== 32'h000) $display("FAIL copy_c1_addr got %h want 00000000", tr_addr[1]); else n_pass++;
        n_checks++; if (tr_wr[2] !== 1'b1 || tr_addr[2] !== 32'h100 || tr_wdata[2] !== 32'h11223344)
            $display("FAIL copy_c2_write got wr=%h addr=%h data=%h want wr=1 addr=00000100 data=11223344",
                     tr_wr[2], tr_addr[2], tr_wdata[2]); else n_pass++;
        n_checks++; if (tr_addr[3] !== 32'h004 || tr_wr[3] !== 1'b0)
            $display("FAIL copy_c3_read got addr=%h wr=%h want addr=00000004 wr=0", tr_addr[3], tr_wr[3]); else n_pass++;
        n_checks++; if (tr_addr[9] !== 32'h0 || tr_wdata[9] !== 32'h0)
            $display("FAIL copy_fin_outputs got addr=%h data=%h want 0 0", tr_addr[9], tr_wdata[9]); else n_pass++;
        n_checks++; if (get_word(12'h100) !== 32'h11223344) $display("FAIL copy_w0 got %h want 11223344", get_word(12'h100)); else n_pass++;
        n_checks++; if (get_word(12'h104) !== 32'h55667788) $display("FAIL copy_w1 got %h want 55667788", get_word(12'h104)); else n_pass++;
        n_checks++; if (get_word(12'h108) !== 32'h99AABBCC) $display("FAIL copy_w2 got %h want 99aabbcc", get_word(12'h108)); else n_pass++;
        n_checks++; if (get_word(12'h10C) !== 32'hDDEEFF00) $display("FAIL copy_w3 got %h want ddeeff00", get_word(12'h10C)); else n_pass++;
        n_checks++; if (get_word(12'h110) !== 32'h0) $display("FAIL copy_past_end got %h want 0", get_word(12'h110)); else n_pass++;
        n_checks++; if (mismatch_cnt !== 16'h0) $display("FAIL copy_mis_cnt got %h want 0", mismatch_cnt); else n_pass++;
    endtask

    task automatic test_compare();
        int dc, bc, dn, wc;
        mem_clear(); load_source();
        put_word(12'h100, 32'h11223344);
        put_word(12'h104, 32'h55660088);
        put_word(12'h108, 32'h99AABBCC);
        put_word(12'h10C, 32'hDDEEFF00);
        run_xfer(1'b1, 32'h000, 32'h100, 16'd4, 0, dc, bc, dn, wc);
        n_checks++; if (mismatch_cnt !== 16'd1) $display("FAIL cmp_mis_cnt got %0d want 1", mismatch_cnt); else n_pass++;
        n_checks++; if (first_mis_addr !== 32'h004) $display("FAIL cmp_first_mis got %h want 00000004", first_mis_addr); else n_pass++;
        n_checks++; if (wc != 0) $display("FAIL cmp_writes got %0d want 0", wc); else n_pass++;
        n_checks++; if (dc != 9 || bc != 9) $display("FAIL cmp_timing got done=%0d busy=%0d want 9 9", dc, bc); else n_pass++;
        // Every destination word differs: count 4, first at source base
        put_word(12'h100, 32'h0);
        put_word(12'h108, 32'h0);
        put_word(12'h10C, 32'h0);
        run_xfer(1'b1, 32'h000, 32'h100, 16'd4, 0, dc, bc, dn, wc);
        n_checks++; if (mismatch_cnt !== 16'd4) $display("FAIL cmp_all_cnt got %0d want 4", mismatch_cnt); else n_pass++;
        n_checks++; if (first_mis_addr !== 32'h000) $display("FAIL cmp_all_first got %h want 00000000", first_mis_addr); else n_pass++;
    endtask

    task automatic test_len_zero();
        int dc, bc, dn, wc;
        run_xfer(1'b0, 32'h040, 32'h080, 16'd0, 0, dc, bc, dn, wc);
        n_checks++; if (dc != 1) $display("FAIL len0_done_cycle got %0d want 1", dc); else n_pass++;
        n_checks++; if (bc != 1) $display("FAIL len0_busy_cycles got %0d want 1", bc); else n_pass++;
        n_checks++; if (wc != 0 || tr_addr[1] !== 32'h0) $display("FAIL len0_access got wr=%0d addr=%h want 0 0", wc, tr_addr[1]); else n_pass++;
        n_checks++; if (mismatch_cnt !== 16'h0) $display("FAIL len0_mis_cleared got %0d want 0", mismatch_cnt); else n_pass++;
    endtask

    task automatic test_overlap();
        int dc, bc, dn, wc;
        mem_clear(); load_source();
        run_xfer(1'b0, 32'h000, 32'h004, 16'd3, 0, dc, bc, dn, wc);
        n_checks++; if (get_word(12'h004) !== 32'h11223344) $display("FAIL ovl_w1 got %h want 11223344", get_word(12'h004)); else n_pass++;
        n_checks++; if (get_word(12'h008) !== 32'h11223344) $display("FAIL ovl_w2 got %h want 11223344", get_word(12'h008)); else n_pass++;
        n_checks++; if (get_word(12'h00C) !== 32'h11223344) $display("FAIL ovl_w3 got %h want 11223344", get_word(12'h00C)); else n_pass++;
        n_checks++; if (dc != 7) $display("FAIL ovl_done_cycle got %0d want 7", dc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dc, bc, dn, wc;
        mem_clear(); load_source();
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src_addr = 32'h000; dst_addr = 32'h100; len_words = 16'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (mem_wr !== 1'b1 || mem_addr !== 32'h108)
            $display("FAIL rst_mid_in_wr got wr=%h addr=%h want 1 00000108", mem_wr, mem_addr); else n_pass++;
        nrst = 1'b0;
        #1;
        n_checks++; if (mem_wr !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_mid_outputs got wr=%h addr=%h data=%h busy=%h done=%h want all 0",
                     mem_wr, mem_addr, mem_wdata, busy, done); else n_pass++;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_checks++; if (get_word(12'h104) !== 32'h55667788) $display("FAIL rst_mid_w1 got %h want 55667788", get_word(12'h104)); else n_pass++;
        n_checks++; if (get_word(12'h108) !== 32'h0 || get_word(12'h10C) !== 32'h0)
            $display("FAIL rst_mid_w23 got %h %h want 0 0", get_word(12'h108), get_word(12'h10C)); else n_pass++;
        run_xfer(1'b0, 32'h000, 32'h100, 16'd4, 0, dc, bc, dn, wc);
        n_checks++; if (dc != 9 || get_word(12'h10C) !== 32'hDDEEFF00)
            $display("FAIL rst_mid_restart got done=%0d w3=%h want 9 ddeeff00", dc, get_word(12'h10C)); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int dc, bc, dn, wc;
        mem_clear(); load_source();
        run_xfer(1'b0, 32'h000, 32'h100, 16'd4, 3, dc, bc, dn, wc);
        n_checks++; if (dn != 1) $display("FAIL ign_done_pulses got %0d want 1", dn); else n_pass++;
        n_checks++; if (dc != 9 || bc != 9) $display("FAIL ign_timing got done=%0d busy=%0d want 9 9", dc, bc); else n_pass++;
        n_checks++; if (get_word(12'h104) !== 32'h55667788 || get_word(12'h10C) !== 32'hDDEEFF00)
            $display("FAIL ign_data got %h %h want 55667788 ddeeff00", get_word(12'h104), get_word(12'h10C)); else n_pass++;
        n_checks++; if (wc != 4) $display("FAIL ign_writes got %0d want 4", wc); else n_pass++;
    endtask

    initial begin
        start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        nrst = 1'b1;
        mem_clear();
        test_reset();
        test_copy();
        test_compare();
        test_len_zero();
        test_overlap();
        test_reset_mid();
        test_ignored_start();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_blk_xfer
`default_nettype wire
